// File: rtl/video_pattern_gen_if.sv
// Video pattern generator bus: control inputs plus registered pixel/sync outputs.
// master = generator side, slave = controller/sink side.
interface video_pattern_gen_if;
    logic       enable;
    logic [1:0] pattern_sel;
    logic [7:0] data_out;
    logic       data_out_en;
    logic       hs_out;
    logic       vs_out;
    logic       frame_start;

    modport master (
        input  enable, pattern_sel,
        output data_out, data_out_en, hs_out, vs_out, frame_start
    );

    modport slave (
        output enable, pattern_sel,
        input  data_out, data_out_en, hs_out, vs_out, frame_start
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Raster timing generator with solid/ramp/checker test patterns and registered outputs.
// Optional salt-and-pepper noise overlay enabled by defining PATTERN_NOISE_EN.
module video_pattern_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    video_pattern_gen_if.master  vid
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          running, at_origin, at_last, pix_act;
    logic [1:0]    pat_q, pat_cur;
    logic [7:0]    x_w, y_w, pix;
`ifdef PATTERN_NOISE_EN
    logic [15:0]   lfsr;
`endif

    always_comb begin
        running   = (state != IDLE);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        at_last   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        pix_act   = running && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END)
                            && (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        // Pattern is latched at the frame origin; use the live input on that cycle itself.
        pat_cur   = at_origin ? vid.pattern_sel : pat_q;
        x_w       = 8'(h_cnt - H_ACT_BEG);
        y_w       = 8'(v_cnt - V_ACT_BEG);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vid.enable) state_nxt = RUN;
            // Dropping enable on the very last pixel ends the frame cleanly without draining another.
            RUN:     if (!vid.enable) state_nxt = at_last ? IDLE : DRAIN;
            DRAIN:   if (vid.enable) state_nxt = RUN;
                     else if (at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        if (running) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_nxt = h_cnt + HW'(1);
                v_nxt = v_cnt;
            end
        end
    end

    always_comb begin
        pix = 8'h00;
        if (pix_act) begin
            case (pat_cur)
                2'd0:    pix = 8'h80;
                2'd1:    pix = x_w;
                2'd2:    pix = y_w;
                default: pix = {8{x_w[3] ^ y_w[3]}};
            endcase
`ifdef PATTERN_NOISE_EN
            if (lfsr[7:0] == 8'h00) pix = lfsr[8] ? 8'hFF : 8'h00;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            pat_q <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (at_origin) pat_q <= vid.pattern_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.data_out    <= '0;
            vid.data_out_en <= 1'b0;
            vid.hs_out      <= 1'b0;
            vid.vs_out      <= 1'b0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.data_out    <= pix;
            vid.data_out_en <= pix_act;
            vid.hs_out      <= running && (h_cnt < H_SYNC_E);
            vid.vs_out      <= running && (v_cnt < V_SYNC_E);
            vid.frame_start <= running && at_origin;
        end
    end

`ifdef PATTERN_NOISE_EN
    // Fibonacci LFSR, taps 16,14,13,11; reseeded at each frame origin so every frame repeats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (running && at_origin) begin
            lfsr <= 16'hACE1;
        end else if (pix_act) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end
`endif
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed self-checking bench for video_pattern_gen (16x8 raster plus a 16x16-active checker instance).
module tb_video_pattern_gen;
    logic clk;
    logic rst_n;

    video_pattern_gen_if vif_a();
    video_pattern_gen_if vif_c();

    video_pattern_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(3),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vif_a)
    );

    video_pattern_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(16), .H_FP(3),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(16), .V_FP(1)
    ) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vif_c)
    );

`ifdef PATTERN_NOISE_EN
    localparam bit NOISE = 1'b1;
`else
    localparam bit NOISE = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  cap_d  [512];
    logic        cap_de [512];
    logic        cap_hs [512];
    logic        cap_vs [512];
    logic        cap_fs [512];
    int          cap_n;
    logic [7:0]  c_d  [300];
    logic        c_de [300];
    logic [15:0] nz   [512];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // i-th valid pixel of a frame: noise overlay applies where the reseeded LFSR low byte is zero
    function automatic logic [7:0] exp_pix(input int i, input logic [7:0] base);
        if (NOISE && nz[i][7:0] == 8'h00) return nz[i][8] ? 8'hFF : 8'h00;
        return base;
    endfunction

    function automatic logic [31:0] outs_a();
        return {19'd0, vif_a.data_out, vif_a.data_out_en, vif_a.hs_out, vif_a.vs_out, vif_a.frame_start};
    endfunction

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_d[cap_n]  = vif_a.data_out;
            cap_de[cap_n] = vif_a.data_out_en;
            cap_hs[cap_n] = vif_a.hs_out;
            cap_vs[cap_n] = vif_a.vs_out;
            cap_fs[cap_n] = vif_a.frame_start;
            cap_n++;
        end
    endtask

    // mode 0 solid, 1 horizontal ramp, 2 vertical ramp; frame occupies 128 samples from s
    task automatic check_frame(input int s, input int mode, input string tag);
        int de_n = 0, hs_n = 0, vs_n = 0, fs_n = 0, runs = 0, bad = 0, leak = 0, i = 0;
        logic [7:0] base;
        for (int k = s; k < s + 128; k++) begin
            de_n += int'(cap_de[k]);
            hs_n += int'(cap_hs[k]);
            vs_n += int'(cap_vs[k]);
            fs_n += int'(cap_fs[k]);
            if (cap_de[k] && (k == s || !cap_de[k-1])) runs++;
            if (cap_de[k]) begin
                base = (mode == 0) ? 8'h80 : (mode == 1) ? 8'(i % 8) : 8'(i / 8);
                if (cap_d[k] !== exp_pix(i, base)) bad++;
                i++;
            end else if (cap_d[k] !== 8'h00) begin
                leak++;
            end
        end
        check({tag, "_de_count"}, de_n, 32);
        check({tag, "_hs_count"}, hs_n, 16);
        check({tag, "_vs_count"}, vs_n, 16);
        check({tag, "_fs_count"}, fs_n, 1);
        check({tag, "_fs_first"}, cap_fs[s], 1);
        check({tag, "_de_lines"}, runs, 4);
        check({tag, "_pix_bad"}, bad, 0);
        check({tag, "_blank_nonzero"}, leak, 0);
    endtask

    initial begin
        int leak;
        logic [15:0] l;

        l = 16'hACE1;
        for (int i = 0; i < 512; i++) begin
            nz[i] = l;
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end

        rst_n = 1'b0;
        vif_a.enable = 1'b0;
        vif_a.pattern_sel = 2'd1;
        vif_c.enable = 1'b0;
        vif_c.pattern_sel = 2'd3;

        repeat (2) @(negedge clk);
        check("rst_data", vif_a.data_out, 0);
        check("rst_de", vif_a.data_out_en, 0);
        check("rst_hs", vif_a.hs_out, 0);
        check("rst_vs", vif_a.vs_out, 0);
        check("rst_fs", vif_a.frame_start, 0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_enable", outs_a(), 0);

        // Frame 1 ramp H, pattern switched to V ramp mid-frame, frame 2 must be V ramp
        vif_a.enable = 1'b1;
        @(negedge clk);
        check("fs_latency", vif_a.frame_start, 0);
        cap_n = 0;
        capture(64);
        vif_a.pattern_sel = 2'd2;
        capture(192);
        check("hs_k1", cap_hs[1], 1);
        check("hs_k2", cap_hs[2], 0);
        check("vs_k15", cap_vs[15], 1);
        check("vs_k16", cap_vs[16], 0);
        check("de_k52", cap_de[52], 0);
        check("de_k53", cap_de[53], 1);
        check("pix_k53", cap_d[53], exp_pix(0, 8'h00));
        check("de_k61", cap_de[61], 0);
        check_frame(0, 1, "ramp_h");
        check_frame(128, 2, "ramp_v");

        // Enable dropped 40 clocks into frame 3: frame completes, then idle
        vif_a.pattern_sel = 2'd1;
        capture(40);
        vif_a.enable = 1'b0;
        capture(100);
        check_frame(256, 1, "drain");
        leak = 0;
        for (int k = 384; k < 396; k++)
            if (cap_d[k] !== 8'h00 || cap_de[k] || cap_hs[k] || cap_vs[k] || cap_fs[k]) leak++;
        check("drain_idle_outputs", leak, 0);

        // Re-raise enable during drain: next frame follows without a gap
        vif_a.enable = 1'b1;
        @(negedge clk);
        cap_n = 0;
        capture(40);
        vif_a.enable = 1'b0;
        capture(20);
        vif_a.enable = 1'b1;
        capture(196);
        check_frame(0, 1, "rerun1");
        check_frame(128, 1, "rerun2");

        // Asynchronous reset in the middle of an active line
        capture(56);
        check("pre_reset_de", cap_de[311], 1);
        rst_n = 1'b0;
        vif_a.enable = 1'b0;
        #1;
        check("async_rst_outputs", outs_a(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        leak = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (outs_a() !== 32'd0) leak++;
        end
        check("post_rst_idle", leak, 0);
        vif_a.enable = 1'b1;
        @(negedge clk);
        check("restart_fs_early", vif_a.frame_start, 0);
        @(negedge clk);
        check("restart_fs", vif_a.frame_start, 1);
        check("restart_hs", vif_a.hs_out, 1);

        // 8x8 checkerboard on the 16x16-active instance (H_TOTAL 24)
        vif_c.enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            c_d[k]  = vif_c.data_out;
            c_de[k] = vif_c.data_out_en;
        end
        check("chk_de_8_0", c_de[85], 1);
        check("chk_pix_8_0", c_d[85], exp_pix(8, 8'hFF));
        check("chk_de_8_8", c_de[277], 1);
        check("chk_pix_8_8", c_d[277], exp_pix(136, 8'h00));
        check("chk_pix_0_0", c_d[77], exp_pix(0, 8'h00));
        check("chk_pix_0_8", c_d[269], exp_pix(128, 8'hFF));

        // Solid pattern, two consecutive frames from reset
        rst_n = 1'b0;
        vif_a.enable = 1'b0;
        vif_c.enable = 1'b0;
        vif_a.pattern_sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        vif_a.enable = 1'b1;
        @(negedge clk);
        cap_n = 0;
        capture(256);
        check_frame(0, 0, "solid1");
        check_frame(128, 0, "solid2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
